// File: rtl/ysyx_25020037_lsu_if.sv
// ysyx_25020037_lsu_if
// Single-beat memory bus between the LSU and the data memory.
//   master (LSU side): drives mem_req_valid/wen/addr/wdata/wstrb,
//                      samples mem_req_ready and mem_resp_valid/rdata/err.
//   slave  (memory side): the mirror image.
interface ysyx_25020037_lsu_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wen;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        mem_resp_err;

    modport master (
        output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
    );

    modport slave (
        input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
    );
endinterface

// File: rtl/ysyx_25020037_lsu.sv
// ysyx_25020037_lsu
// Load/store unit between EXU and WBU of the RV32E pipeline.
//   clk, rst           : clock, synchronous active-high reset
//   exu_valid/lsu_ready: EXU -> LSU record handshake (pc, rd, gpr_we, is_read,
//                        is_write, lw_lh_lb, sw_sh_sb, ld_unsigned, addr, wdata)
//   mem                : single-beat memory bus (master modport)
//   lsu_valid/wbu_ready: LSU -> WBU record handshake (lu_pc, lu_rd, lu_gpr_we,
//                        lu_wdata, lu_err)
//   rdata_processed    : last completed load value, for the EXU bypass network
// Optional: define YSYX_25020037_LSU_MISALIGN_CHECK_EN to fault misaligned
// half/word accesses locally instead of sending them to memory.
module ysyx_25020037_lsu (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       exu_valid,
    output logic                       lsu_ready,
    input  logic [31:0]                pc,
    input  logic [3:0]                 rd,
    input  logic                       gpr_we,
    input  logic                       is_read,
    input  logic                       is_write,
    input  logic [1:0]                 lw_lh_lb,
    input  logic [1:0]                 sw_sh_sb,
    input  logic                       ld_unsigned,
    input  logic [31:0]                addr,
    input  logic [31:0]                wdata,
    output logic [31:0]                rdata_processed,
    ysyx_25020037_lsu_if.master        mem,
    output logic                       lsu_valid,
    input  logic                       wbu_ready,
    output logic [31:0]                lu_pc,
    output logic [3:0]                 lu_rd,
    output logic                       lu_gpr_we,
    output logic [31:0]                lu_wdata,
    output logic                       lu_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    // Only what the response edge still needs; store data is formatted at accept.
    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  rd;
        logic        gpr_we;
        logic        is_read;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  off;
    } rec_t;

    state_e      state_q, state_d;
    rec_t        rec_q, rec_d;
    logic        req_valid_q, req_valid_d, req_wen_q, req_wen_d;
    logic [31:0] req_addr_q, req_addr_d, req_wdata_q, req_wdata_d;
    logic [3:0]  req_wstrb_q, req_wstrb_d;
    logic        lsu_valid_q, lsu_valid_d, lu_gpr_we_q, lu_gpr_we_d, lu_err_q, lu_err_d;
    logic [31:0] lu_pc_q, lu_pc_d, lu_wdata_q, lu_wdata_d, rdata_q, rdata_d;
    logic [3:0]  lu_rd_q, lu_rd_d;

    logic        accept, is_mem, misalign;
    logic [1:0]  off;
    logic [31:0] st_wdata, shifted, ld_val;
    logic [3:0]  st_wstrb;

    assign lsu_ready = (state_q == IDLE) & (~lsu_valid_q | wbu_ready);
    assign accept    = exu_valid & lsu_ready;
    assign is_mem    = is_read | is_write;
    assign off       = addr[1:0];

`ifdef YSYX_25020037_LSU_MISALIGN_CHECK_EN
    logic [1:0] acc_size;
    assign acc_size = is_read ? lw_lh_lb : sw_sh_sb;
    // Reserved size 11 is a word access, hence the acc_size[1] test.
    assign misalign = ((acc_size == 2'b01) & off[0]) | (acc_size[1] & (off != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Lane replication lets memory pick the bytes by strobe alone.
    // Shifted strobes fall off the top for misaligned accesses.
    always_comb begin
        case (sw_sh_sb)
            2'b00: begin
                st_wdata = {4{wdata[7:0]}};
                st_wstrb = 4'b0001 << off;
            end
            2'b01: begin
                st_wdata = {2{wdata[15:0]}};
                st_wstrb = 4'b0011 << off;
            end
            default: begin
                st_wdata = wdata;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    // Memory returns the aligned word; move the addressed byte to lane 0.
    assign shifted = mem.mem_resp_rdata >> {rec_q.off, 3'b000};

    always_comb begin
        case (rec_q.size)
            2'b00:   ld_val = {{24{shifted[7]  & ~rec_q.uns}}, shifted[7:0]};
            2'b01:   ld_val = {{16{shifted[15] & ~rec_q.uns}}, shifted[15:0]};
            default: ld_val = shifted;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rec_d       = rec_q;
        req_valid_d = req_valid_q;
        req_wen_d   = req_wen_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_wstrb_d = req_wstrb_q;
        lsu_valid_d = lsu_valid_q;
        lu_pc_d     = lu_pc_q;
        lu_rd_d     = lu_rd_q;
        lu_gpr_we_d = lu_gpr_we_q;
        lu_wdata_d  = lu_wdata_q;
        lu_err_d    = lu_err_q;
        rdata_d     = rdata_q;

        // WBU handshake empties the slot; a same-edge reload below overrides this.
        if (lsu_valid_q & wbu_ready) lsu_valid_d = 1'b0;

        case (state_q)
            IDLE: if (accept) begin
                rec_d.pc      = pc;
                rec_d.rd      = rd;
                rec_d.gpr_we  = gpr_we;
                rec_d.is_read = is_read;
                rec_d.size    = lw_lh_lb;
                rec_d.uns     = ld_unsigned;
                rec_d.off     = off;
                if (!is_mem || misalign) begin
                    lsu_valid_d = 1'b1;
                    lu_pc_d     = pc;
                    lu_rd_d     = rd;
                    lu_gpr_we_d = is_mem ? 1'b0 : gpr_we;
                    lu_wdata_d  = is_mem ? 32'h0 : addr;
                    lu_err_d    = is_mem;
                end else begin
                    state_d     = REQ;
                    req_valid_d = 1'b1;
                    req_wen_d   = is_write;
                    req_addr_d  = addr;
                    req_wdata_d = st_wdata;
                    req_wstrb_d = is_write ? st_wstrb : 4'b0000;
                end
            end
            REQ: if (mem.mem_req_ready) begin
                state_d     = WAIT;
                req_valid_d = 1'b0;
            end
            WAIT: if (mem.mem_resp_valid) begin
                // The output slot was emptied at accept, so it is free here.
                state_d     = IDLE;
                lsu_valid_d = 1'b1;
                lu_pc_d     = rec_q.pc;
                lu_rd_d     = rec_q.rd;
                if (mem.mem_resp_err) begin
                    lu_gpr_we_d = 1'b0;
                    lu_wdata_d  = 32'h0;
                    lu_err_d    = 1'b1;
                end else begin
                    lu_gpr_we_d = rec_q.gpr_we;
                    lu_err_d    = 1'b0;
                    lu_wdata_d  = rec_q.is_read ? ld_val : 32'h0;
                    if (rec_q.is_read) rdata_d = ld_val;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rec_q       <= '0;
            req_valid_q <= 1'b0;
            req_wen_q   <= 1'b0;
            req_addr_q  <= 32'h0;
            req_wdata_q <= 32'h0;
            req_wstrb_q <= 4'h0;
            lsu_valid_q <= 1'b0;
            lu_pc_q     <= 32'h0;
            lu_rd_q     <= 4'h0;
            lu_gpr_we_q <= 1'b0;
            lu_wdata_q  <= 32'h0;
            lu_err_q    <= 1'b0;
            rdata_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            rec_q       <= rec_d;
            req_valid_q <= req_valid_d;
            req_wen_q   <= req_wen_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_wstrb_q <= req_wstrb_d;
            lsu_valid_q <= lsu_valid_d;
            lu_pc_q     <= lu_pc_d;
            lu_rd_q     <= lu_rd_d;
            lu_gpr_we_q <= lu_gpr_we_d;
            lu_wdata_q  <= lu_wdata_d;
            lu_err_q    <= lu_err_d;
            rdata_q     <= rdata_d;
        end
    end

    assign mem.mem_req_valid = req_valid_q;
    assign mem.mem_req_wen   = req_wen_q;
    assign mem.mem_req_addr  = req_addr_q;
    assign mem.mem_req_wdata = req_wdata_q;
    assign mem.mem_req_wstrb = req_wstrb_q;
    assign lsu_valid         = lsu_valid_q;
    assign lu_pc             = lu_pc_q;
    assign lu_rd             = lu_rd_q;
    assign lu_gpr_we         = lu_gpr_we_q;
    assign lu_wdata          = lu_wdata_q;
    assign lu_err            = lu_err_q;
    assign rdata_processed   = rdata_q;
endmodule

// File: tb/tb_ysyx_25020037_lsu.sv
// tb_ysyx_25020037_lsu
// Scoreboard bench: the driver computes each record's expected write-back
// (and expected memory request) from the load/store rules and queues them;
// a memory responder and a WBU monitor pop and compare independently.
module tb_ysyx_25020037_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exu_valid = 1'b0, gpr_we = 1'b0, is_read = 1'b0, is_write = 1'b0, ld_unsigned = 1'b0;
    logic [31:0] pc = 32'h0, addr = 32'h0, wdata = 32'h0;
    logic [3:0]  rd = 4'h0;
    logic [1:0]  lw_lh_lb = 2'b0, sw_sh_sb = 2'b0;
    logic        wbu_ready = 1'b1;
    logic        lsu_ready, lsu_valid, lu_gpr_we, lu_err;
    logic [31:0] rdata_processed, lu_pc, lu_wdata;
    logic [3:0]  lu_rd;

    always #5 clk = ~clk;

    ysyx_25020037_lsu_if mif();

    ysyx_25020037_lsu dut (
        .clk(clk), .rst(rst), .exu_valid(exu_valid), .lsu_ready(lsu_ready),
        .pc(pc), .rd(rd), .gpr_we(gpr_we), .is_read(is_read), .is_write(is_write),
        .lw_lh_lb(lw_lh_lb), .sw_sh_sb(sw_sh_sb), .ld_unsigned(ld_unsigned),
        .addr(addr), .wdata(wdata), .rdata_processed(rdata_processed), .mem(mif),
        .lsu_valid(lsu_valid), .wbu_ready(wbu_ready), .lu_pc(lu_pc), .lu_rd(lu_rd),
        .lu_gpr_we(lu_gpr_we), .lu_wdata(lu_wdata), .lu_err(lu_err)
    );

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  rd;
        logic        we;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rp;
    } wb_t;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] rdata;
        logic        err;
    } mreq_t;

    wb_t         wb_q[$];
    mreq_t       req_q[$];
    int          vec = 0, miss = 0;
    logic [31:0] last_ld = 32'h0;
    bit          resp_en = 1'b0, wbu_rand_en = 1'b0;
    int          ready_dly = -1, resp_dly = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Byte i of the result is memory byte (offset+i); bytes past the word read as 0.
    function automatic logic [31:0] ld_model(input logic [31:0] r, input logic [1:0] o,
                                             input logic [1:0] sz, input logic uns);
        logic [63:0] w;
        logic [7:0]  b [4];
        w = {32'h0, r};
        for (int i = 0; i < 4; i++) b[i] = w[8*(int'(o)+i) +: 8];
        case (sz)
            2'b00:   return uns ? {24'h0, b[0]} : {{24{b[0][7]}}, b[0]};
            2'b01:   return uns ? {16'h0, b[1], b[0]} : {{16{b[1][7]}}, b[1], b[0]};
            default: return {b[3], b[2], b[1], b[0]};
        endcase
    endfunction

    function automatic logic [3:0] strb_model(input logic [1:0] o, input logic [1:0] sz);
        logic [3:0] s;
        int n;
        n = (sz == 2'b00) ? 1 : 2;
        for (int i = 0; i < 4; i++) s[i] = (sz[1] == 1'b1) || (i >= int'(o) && i < int'(o) + n);
        return s;
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the accept edge.
    task automatic issue(input logic [31:0] ipc, input logic [3:0] ird, input logic iwe,
                         input logic rdop, input logic wrop, input logic [1:0] lsz,
                         input logic [1:0] ssz, input logic uns, input logic [31:0] iaddr,
                         input logic [31:0] iwd, input logic [31:0] rr, input logic rerr);
        wb_t   e;
        mreq_t q;
        logic [1:0] o, sz;
        bit mis, ok;
        o  = iaddr[1:0];
        sz = rdop ? lsz : ssz;
`ifdef YSYX_25020037_LSU_MISALIGN_CHECK_EN
        mis = (sz == 2'b01 && o[0]) || (sz[1] && o != 2'b00);
`else
        mis = 1'b0;
`endif
        e.pc = ipc; e.rd = ird; e.we = iwe; e.wd = 32'h0; e.err = 1'b0;
        if (!rdop && !wrop) begin
            e.wd = iaddr;
        end else if (mis) begin
            e.we = 1'b0; e.err = 1'b1;
        end else begin
            q.wen   = wrop;
            q.addr  = iaddr;
            q.strb  = wrop ? strb_model(o, ssz) : 4'b0000;
            q.wdata = (ssz == 2'b00) ? {4{iwd[7:0]}} : (ssz == 2'b01) ? {2{iwd[15:0]}} : iwd;
            q.rdata = rr;
            q.err   = rerr;
            req_q.push_back(q);
            if (rerr) begin
                e.we = 1'b0; e.err = 1'b1;
            end else if (rdop) begin
                e.wd = ld_model(rr, o, lsz, uns);
                last_ld = e.wd;
            end
        end
        e.rp = last_ld;
        wb_q.push_back(e);

        pc = ipc; rd = ird; gpr_we = iwe; is_read = rdop; is_write = wrop;
        lw_lh_lb = lsz; sw_sh_sb = ssz; ld_unsigned = uns; addr = iaddr; wdata = iwd;
        exu_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (lsu_ready) ok = 1'b1;
        end
        if (!ok) begin
            vec++; miss++;
            $display("FAIL accept_timeout: lsu_ready stuck %b expected 1", lsu_ready);
        end
        @(posedge clk); #1;
        exu_valid = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (lsu_valid) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk(nm, {31'h0, ok}, 32'h1);
    endtask

    // WBU back-pressure
    initial begin
        forever begin
            @(posedge clk); #1;
            if (wbu_rand_en) wbu_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Memory model: checks each request, stalls ready, returns the queued response.
    initial begin
        mreq_t r;
        int d;
        mif.mem_req_ready = 1'b0; mif.mem_resp_valid = 1'b0;
        mif.mem_resp_rdata = 32'h0; mif.mem_resp_err = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (resp_en && !rst && mif.mem_req_valid) begin
                if (req_q.size() == 0) begin
                    vec++; miss++;
                    $display("FAIL req_unexpected: addr %h expected no request", mif.mem_req_addr);
                    r = '{default: '0};
                end else r = req_q.pop_front();
                chk("req_wen", {31'h0, mif.mem_req_wen}, {31'h0, r.wen});
                chk("req_addr", mif.mem_req_addr, r.addr);
                chk("req_wstrb", {28'h0, mif.mem_req_wstrb}, {28'h0, r.strb});
                if (r.wen) chk("req_wdata", mif.mem_req_wdata, r.wdata);
                d = (ready_dly >= 0) ? ready_dly : $urandom_range(0, 3);
                for (int k = 0; k < d; k++) begin
                    // responses while still in REQ must be ignored
                    mif.mem_req_ready  = 1'b0;
                    mif.mem_resp_valid = 1'($urandom_range(0, 1));
                    mif.mem_resp_rdata = $urandom;
                    mif.mem_resp_err   = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                    chk("req_hold_valid", {31'h0, mif.mem_req_valid}, 32'h1);
                    chk("req_hold_addr", mif.mem_req_addr, r.addr);
                end
                mif.mem_req_ready = 1'b1; mif.mem_resp_valid = 1'b0;
                @(posedge clk); #1;
                chk("req_drop", {31'h0, mif.mem_req_valid}, 32'h0);
                d = (resp_dly >= 0) ? resp_dly : $urandom_range(0, 2);
                for (int k = 0; k < d; k++) begin
                    mif.mem_req_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                mif.mem_req_ready  = 1'b0;
                mif.mem_resp_valid = 1'b1;
                mif.mem_resp_rdata = r.rdata;
                mif.mem_resp_err   = r.err;
                @(posedge clk); #1;
                mif.mem_resp_valid = 1'b0;
                mif.mem_resp_err   = 1'b0;
            end else if (resp_en) begin
                // stray ready/response while idle must be ignored
                mif.mem_req_ready  = 1'($urandom_range(0, 1));
                mif.mem_resp_valid = 1'($urandom_range(0, 1));
                mif.mem_resp_rdata = $urandom;
                mif.mem_resp_err   = 1'($urandom_range(0, 1));
            end else begin
                mif.mem_req_ready = 1'b0; mif.mem_resp_valid = 1'b0; mif.mem_resp_err = 1'b0;
            end
        end
    end

    // WBU monitor
    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mif.mem_req_valid) chk("busy_lsu_ready", {31'h0, lsu_ready}, 32'h0);
                if (lsu_valid) begin
                    if (wb_q.size() == 0) begin
                        vec++; miss++;
                        $display("FAIL wb_unexpected: lu_pc %h expected no record", lu_pc);
                    end else begin
                        e = wb_q[0];
                        chk("wb_pc", lu_pc, e.pc);
                        chk("wb_rd", {28'h0, lu_rd}, {28'h0, e.rd});
                        chk("wb_we", {31'h0, lu_gpr_we}, {31'h0, e.we});
                        chk("wb_wdata", lu_wdata, e.wd);
                        chk("wb_err", {31'h0, lu_err}, {31'h0, e.err});
                        chk("wb_rdata_processed", rdata_processed, e.rp);
                        if (wbu_ready) void'(wb_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        bit ok;
        int kind;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_lsu_ready", {31'h0, lsu_ready}, 32'h1);
        chk("rst_lsu_valid", {31'h0, lsu_valid}, 32'h0);
        chk("rst_req_valid", {31'h0, mif.mem_req_valid}, 32'h0);
        chk("rst_req_wen", {31'h0, mif.mem_req_wen}, 32'h0);
        chk("rst_req_addr", mif.mem_req_addr, 32'h0);
        chk("rst_req_wdata", mif.mem_req_wdata, 32'h0);
        chk("rst_req_wstrb", {28'h0, mif.mem_req_wstrb}, 32'h0);
        chk("rst_lu_pc", lu_pc, 32'h0);
        chk("rst_lu_rd", {28'h0, lu_rd}, 32'h0);
        chk("rst_lu_we", {31'h0, lu_gpr_we}, 32'h0);
        chk("rst_lu_wdata", lu_wdata, 32'h0);
        chk("rst_lu_err", {31'h0, lu_err}, 32'h0);
        chk("rst_rdata_processed", rdata_processed, 32'h0);
        @(posedge clk); #1;
        resp_en = 1'b1;
        wbu_ready = 1'b1;

        // add x5
        issue(32'h100, 4'd5, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h1234, 32'h0, 32'h0, 1'b0);
        chk("add_valid_n1", {31'h0, lsu_valid}, 32'h1);
        chk("add_wdata", lu_wdata, 32'h1234);
        chk("add_rd", {28'h0, lu_rd}, 32'h5);

        // lb / lbu at byte 3
        issue(32'h104, 4'd6, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 32'h8000_0003, 32'h0, 32'h80FF_0000, 1'b0);
        wait_valid("lb_done");
        chk("lb_wdata", lu_wdata, 32'hFFFF_FF80);
        chk("lb_rdata_processed", rdata_processed, 32'hFFFF_FF80);
        issue(32'h108, 4'd7, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 32'h8000_0003, 32'h0, 32'h80FF_0000, 1'b0);
        wait_valid("lbu_done");
        chk("lbu_wdata", lu_wdata, 32'h0000_0080);

        // sh at offset 2
        issue(32'h10C, 4'd0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 32'h8000_0002, 32'hABCD_1234, 32'h0, 1'b0);
        chk("sh_wen", {31'h0, mif.mem_req_wen}, 32'h1);
        chk("sh_wstrb", {28'h0, mif.mem_req_wstrb}, 32'hC);
        chk("sh_wdata", mif.mem_req_wdata, 32'h1234_1234);
        wait_valid("sh_done");
        chk("sh_gpr_we", {31'h0, lu_gpr_we}, 32'h0);

        // lw with slow ready and WBU stall
        @(posedge clk); #1;
        wbu_rand_en = 1'b0; ready_dly = 3; resp_dly = 1;
        issue(32'h110, 4'd8, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 32'h8000_0010, 32'h0, 32'h1357_9BDF, 1'b0);
        wbu_ready = 1'b0;
        for (int i = 0; i < 20 && !lsu_valid; i++) begin
            chk("lw_busy_ready", {31'h0, lsu_ready}, 32'h0);
            @(posedge clk); #1;
        end
        chk("lw_done", {31'h0, lsu_valid}, 32'h1);
        chk("lw_wdata", lu_wdata, 32'h1357_9BDF);
        repeat (2) begin
            @(posedge clk); #1;
            chk("lw_stall_ready", {31'h0, lsu_ready}, 32'h0);
            chk("lw_stall_valid", {31'h0, lsu_valid}, 32'h1);
            chk("lw_stall_wdata", lu_wdata, 32'h1357_9BDF);
        end
        wbu_ready = 1'b1;
        @(posedge clk); #1;
        chk("lw_released", {31'h0, lsu_valid}, 32'h0);
        ready_dly = -1; resp_dly = -1;

        // lw with bus error
        issue(32'h114, 4'd9, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 32'h8000_0020, 32'h0, 32'hDEAD_BEEF, 1'b1);
        wait_valid("lwerr_done");
        chk("lwerr_err", {31'h0, lu_err}, 32'h1);
        chk("lwerr_we", {31'h0, lu_gpr_we}, 32'h0);
        chk("lwerr_rdata_processed", rdata_processed, 32'h1357_9BDF);
        @(posedge clk); #1;

        // misaligned lw
        issue(32'h118, 4'd10, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 32'h8000_0002, 32'h0, 32'h4433_2211, 1'b0);
`ifdef YSYX_25020037_LSU_MISALIGN_CHECK_EN
        chk("mis_valid_n1", {31'h0, lsu_valid}, 32'h1);
        chk("mis_err", {31'h0, lu_err}, 32'h1);
        chk("mis_no_req", {31'h0, mif.mem_req_valid}, 32'h0);
`else
        chk("mis_req_valid", {31'h0, mif.mem_req_valid}, 32'h1);
        chk("mis_req_addr", mif.mem_req_addr, 32'h8000_0002);
        wait_valid("mis_done");
`endif

        // randomized traffic
        wbu_rand_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 2);
            issue($urandom, 4'($urandom), 1'($urandom), kind == 1, kind == 2,
                  2'($urandom), 2'($urandom), 1'($urandom),
                  (($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h0) | 32'($urandom_range(0, 255)),
                  $urandom, $urandom, $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(posedge clk); #1;
            if (wb_q.size() == 0 && req_q.size() == 0) ok = 1'b1;
        end
        chk("drain", {31'h0, ok}, 32'h1);

        // reset while a request is outstanding
        wbu_rand_en = 1'b0; wbu_ready = 1'b1; resp_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        is_read = 1'b1; is_write = 1'b0; lw_lh_lb = 2'b10; addr = 32'h8000_0040; exu_valid = 1'b1;
        @(posedge clk); #1;
        exu_valid = 1'b0;
        chk("rstmid_req", {31'h0, mif.mem_req_valid}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstmid_req_gone", {31'h0, mif.mem_req_valid}, 32'h0);
        chk("rstmid_ready", {31'h0, lsu_ready}, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        chk("rstmid_no_record", {31'h0, lsu_valid}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
